// File: rtl/branch_predict_unit_if.sv
// Lookup, prediction and commit-training signals of branch_predict_unit.
// master: fetch/predecode + writeback side; slave: the predictor.
interface branch_predict_unit_if #(
   parameter int BHR_WID = 8
);
   logic               lk_valid;
   logic               lk_stall;
   logic [31:0]        lk_pc;
   logic               lk_is_direct;
   logic               lk_is_cond;
   logic               lk_is_call;
   logic               lk_is_ret;
   logic               flush;

   logic               pred_valid;
   logic               pred_taken;
   logic [31:0]        pred_target;
   logic [BHR_WID-1:0] pred_ghr;

   logic               up_valid;
   logic [31:0]        up_pc;
   logic               up_is_direct;
   logic               up_is_cond;
   logic               up_taken;
   logic [31:0]        up_target;
   logic [BHR_WID-1:0] up_ghr;

   modport master (
      output lk_valid, lk_stall, lk_pc, lk_is_direct, lk_is_cond, lk_is_call, lk_is_ret, flush,
      output up_valid, up_pc, up_is_direct, up_is_cond, up_taken, up_target, up_ghr,
      input  pred_valid, pred_taken, pred_target, pred_ghr
   );

   modport slave (
      input  lk_valid, lk_stall, lk_pc, lk_is_direct, lk_is_cond, lk_is_call, lk_is_ret, flush,
      input  up_valid, up_pc, up_is_direct, up_is_cond, up_taken, up_target, up_ghr,
      output pred_valid, pred_taken, pred_target, pred_ghr
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predictor: fully-associative FIFO-replaced BTB for direct jumps,
// gshare PHT plus target cache for conditional branches, committed GHR.
// Registered prediction one cycle after an accepted lookup.
// Optional return-address stack enabled by defining BPU_RAS_EN.
module branch_predict_unit #(
   parameter int BTB_NUM     = 16,
   parameter int BTB_TAG_WID = 12,
   parameter int BHR_WID     = 8,
   parameter int RAS_DEPTH   = 8
) (
   input logic                  clk,
   input logic                  rst,
   branch_predict_unit_if.slave bus
);
   localparam int PHT_NUM = 2 ** BHR_WID;
   localparam int PTR_WID = $clog2(BTB_NUM);

   logic                   btb_valid  [BTB_NUM];
   logic [BTB_TAG_WID-1:0] btb_tag    [BTB_NUM];
   logic [31:0]            btb_target [BTB_NUM];
   logic [PTR_WID-1:0]     btb_ptr;

   logic [1:0]             pht      [PHT_NUM];
   logic [31:0]            tc       [PHT_NUM];
   logic                   tc_valid [PHT_NUM];
   logic [BHR_WID-1:0]     ghr;

   logic                   lk_accept;
   logic                   lk_hit;
   logic [31:0]            lk_hit_target;
   logic [BHR_WID-1:0]     lk_idx;
   logic                   up_hit;
   logic [PTR_WID-1:0]     up_hit_sel;
   logic [BHR_WID-1:0]     up_idx;
   logic                   nxt_taken;
   logic [31:0]            nxt_target;

`ifdef BPU_RAS_EN
   localparam int RAS_PTR_WID = $clog2(RAS_DEPTH);
   localparam int RAS_CNT_WID = RAS_PTR_WID + 1;
   localparam logic [RAS_CNT_WID-1:0] RAS_FULL = RAS_CNT_WID'(RAS_DEPTH);

   logic [31:0]            ras_stack [RAS_DEPTH];
   logic [RAS_PTR_WID-1:0] ras_ptr;
   logic [RAS_PTR_WID-1:0] ras_top;
   logic [RAS_CNT_WID-1:0] ras_count;
`else
   logic                   unused_ras;

   // Call/return hints have no consumer without the return stack
   always_comb unused_ras = ^{bus.lk_is_call, bus.lk_is_ret, RAS_DEPTH[0]};
`endif

   logic unused_pc_bits;

   // Only the tag/index slices of the PCs feed the tables
   always_comb unused_pc_bits = ^{bus.lk_pc[31:BTB_TAG_WID+2], bus.lk_pc[1:0],
                                  bus.up_pc[31:BTB_TAG_WID+2], bus.up_pc[1:0]};

   // Acceptance qualifier and gshare indices for lookup and training
   always_comb begin
      lk_accept = bus.lk_valid & ~bus.lk_stall & ~bus.flush;
      lk_idx    = ghr ^ bus.lk_pc[BHR_WID+1:2];
      up_idx    = bus.up_ghr ^ bus.up_pc[BHR_WID+1:2];
   end

   // Associative BTB match for the lookup PC and the committed PC
   always_comb begin
      lk_hit        = 1'b0;
      lk_hit_target = '0;
      up_hit        = 1'b0;
      up_hit_sel    = '0;
      for (int unsigned i = 0; i < BTB_NUM; i++) begin
         if (btb_valid[i] && btb_tag[i] == bus.lk_pc[BTB_TAG_WID+1:2]) begin
            lk_hit        = 1'b1;
            lk_hit_target = btb_target[i];
         end
         if (btb_valid[i] && btb_tag[i] == bus.up_pc[BTB_TAG_WID+1:2]) begin
            up_hit     = 1'b1;
            up_hit_sel = PTR_WID'(i);
         end
      end
   end

   // Prediction decision from pre-update table contents (read-before-write)
   always_comb begin
      nxt_taken  = 1'b0;
      nxt_target = '0;
      if (bus.lk_is_direct) begin
         nxt_taken  = lk_hit;
         nxt_target = lk_hit_target;
      end else if (bus.lk_is_cond) begin
         if (pht[lk_idx][1] && (lk_hit || tc_valid[lk_idx])) begin
            nxt_taken  = 1'b1;
            nxt_target = lk_hit ? lk_hit_target : tc[lk_idx];
         end
      end
`ifdef BPU_RAS_EN
      if (bus.lk_is_ret && ras_count != '0) begin
         nxt_taken  = 1'b1;
         nxt_target = ras_stack[ras_top];
      end
`endif
   end

   // Prediction registers plus BTB/PHT/TC/GHR training
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.pred_valid  <= 1'b0;
         bus.pred_taken  <= 1'b0;
         bus.pred_target <= '0;
         bus.pred_ghr    <= '0;
         ghr             <= '0;
         btb_ptr         <= '0;
         for (int unsigned i = 0; i < BTB_NUM; i++) btb_valid[i] <= 1'b0;
         for (int unsigned i = 0; i < PHT_NUM; i++) begin
            pht[i]      <= 2'b01;
            tc_valid[i] <= 1'b0;
         end
      end else begin
         if (bus.flush) begin
            bus.pred_valid <= 1'b0;
         end else if (!bus.lk_stall) begin
            bus.pred_valid <= bus.lk_valid;
            if (bus.lk_valid) begin
               bus.pred_taken  <= nxt_taken;
               bus.pred_target <= nxt_target;
               bus.pred_ghr    <= ghr;
            end
         end

         if (bus.up_valid && bus.up_is_direct) begin
            if (up_hit) begin
               btb_target[up_hit_sel] <= bus.up_target;
            end else begin
               btb_valid[btb_ptr]  <= 1'b1;
               btb_tag[btb_ptr]    <= bus.up_pc[BTB_TAG_WID+1:2];
               btb_target[btb_ptr] <= bus.up_target;
               btb_ptr             <= btb_ptr + PTR_WID'(1);
            end
         end

         if (bus.up_valid && bus.up_is_cond) begin
            if (bus.up_taken) begin
               if (pht[up_idx] != 2'b11) pht[up_idx] <= pht[up_idx] + 2'd1;
               tc[up_idx]       <= bus.up_target;
               tc_valid[up_idx] <= 1'b1;
            end else if (pht[up_idx] != 2'b00) begin
               pht[up_idx] <= pht[up_idx] - 2'd1;
            end
            ghr <= {ghr[BHR_WID-2:0], bus.up_taken};
         end
      end
   end

`ifdef BPU_RAS_EN
   // Entry below the push pointer is the top of stack
   always_comb ras_top = ras_ptr - RAS_PTR_WID'(1);

   // Return stack: circular buffer, push overwrites oldest when full
   always_ff @(posedge clk) begin
      if (rst) begin
         ras_ptr   <= '0;
         ras_count <= '0;
      end else if (lk_accept) begin
         if (bus.lk_is_call) begin
            ras_stack[ras_ptr] <= bus.lk_pc + 32'd4;
            ras_ptr            <= ras_ptr + RAS_PTR_WID'(1);
            if (ras_count != RAS_FULL) ras_count <= ras_count + RAS_CNT_WID'(1);
         end else if (bus.lk_is_ret && ras_count != '0) begin
            ras_ptr   <= ras_top;
            ras_count <= ras_count - RAS_CNT_WID'(1);
         end
      end
   end
`else
   logic unused_accept;

   // Acceptance only steers the return stack
   always_comb unused_accept = lk_accept;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: vector table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
// Define BPU_RAS_EN for both RTL and bench to exercise the return stack.
module tb_branch_predict_unit;
   localparam int BTB_NUM   = 16;
   localparam int BTB_TAG   = 12;
   localparam int BHR       = 8;
   localparam int RAS_DEPTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   branch_predict_unit_if #(.BHR_WID(BHR)) bus ();

   branch_predict_unit #(
      .BTB_NUM    (BTB_NUM),
      .BTB_TAG_WID(BTB_TAG),
      .BHR_WID    (BHR),
      .RAS_DEPTH  (RAS_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] pc; logic [31:0] tgt; } btb_ent_t;
   btb_ent_t    m_btb [$];
   int          m_pht [256];
   logic [31:0] m_tc  [256];
   bit          m_tcv [256];
   int          m_ghr;
   logic [31:0] m_ras [$];
   bit          e_valid, e_taken;
   logic [31:0] e_target;
   logic [7:0]  e_ghr;

   function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
      return ((a >> 2) & 32'hFFF) == ((b >> 2) & 32'hFFF);
   endfunction

   function automatic int btb_find(input logic [31:0] pc);
      for (int i = 0; i < m_btb.size(); i++) if (same_tag(m_btb[i].pc, pc)) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_btb.delete();
      m_ras.delete();
      for (int i = 0; i < 256; i++) begin
         m_pht[i] = 1; m_tcv[i] = 0; m_tc[i] = '0;
      end
      m_ghr = 0; e_valid = 0; e_taken = 0; e_target = '0; e_ghr = '0;
   endtask

   task automatic model_step(input bit lv, ls, fl, input logic [31:0] pc,
                             input bit dir, cond, call, ret,
                             input bit uv, udir, ucond, ut,
                             input logic [31:0] upc, utgt, input logic [7:0] ughr);
      bit tk; logic [31:0] tg; int hit; int idx; int ui;
      tk = 0; tg = '0;
      if (lv && !ls && !fl) begin
         hit = btb_find(pc);
         idx = (m_ghr ^ int'(pc >> 2)) & 255;
         if (dir) begin
            if (hit >= 0) begin tk = 1; tg = m_btb[hit].tgt; end
         end else if (cond) begin
            if (m_pht[idx] >= 2 && (hit >= 0 || m_tcv[idx])) begin
               tk = 1; tg = (hit >= 0) ? m_btb[hit].tgt : m_tc[idx];
            end
         end
`ifdef BPU_RAS_EN
         if (call) begin
            m_ras.push_back(pc + 32'd4);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
         end else if (ret && m_ras.size() > 0) begin
            tk = 1; tg = m_ras.pop_back();
         end
`endif
      end
      if (fl) e_valid = 0;
      else if (!ls) begin
         e_valid = lv;
         if (lv) begin e_taken = tk; e_target = tg; e_ghr = 8'(m_ghr); end
      end
      if (uv && udir) begin
         hit = btb_find(upc);
         if (hit >= 0) m_btb[hit].tgt = utgt;
         else begin
            m_btb.push_back('{upc, utgt});
            if (m_btb.size() > BTB_NUM) void'(m_btb.pop_front());
         end
      end
      if (uv && ucond) begin
         ui = (int'(ughr) ^ int'(upc >> 2)) & 255;
         if (ut) begin
            if (m_pht[ui] < 3) m_pht[ui]++;
            m_tc[ui] = utgt; m_tcv[ui] = 1;
         end else if (m_pht[ui] > 0) m_pht[ui]--;
         m_ghr = ((m_ghr << 1) | int'(ut)) & 255;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_in();
      bus.lk_valid = 0; bus.lk_stall = 0; bus.lk_pc = '0; bus.lk_is_direct = 0;
      bus.lk_is_cond = 0; bus.lk_is_call = 0; bus.lk_is_ret = 0; bus.flush = 0;
      bus.up_valid = 0; bus.up_pc = '0; bus.up_is_direct = 0; bus.up_is_cond = 0;
      bus.up_taken = 0; bus.up_target = '0; bus.up_ghr = '0;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1; tick(); tick();
      rst = 0;
      model_reset();
   endtask

   task automatic lookup(input logic [31:0] pc, input bit dir, cond, call, ret);
      bus.lk_valid = 1; bus.lk_pc = pc; bus.lk_is_direct = dir; bus.lk_is_cond = cond;
      bus.lk_is_call = call; bus.lk_is_ret = ret;
      tick();
      clear_in();
   endtask

   task automatic upd_dir(input logic [31:0] pc, input logic [31:0] tgt);
      bus.up_valid = 1; bus.up_is_direct = 1; bus.up_pc = pc; bus.up_target = tgt;
      tick();
      clear_in();
   endtask

   task automatic upd_cond(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                           input logic [7:0] g);
      bus.up_valid = 1; bus.up_is_cond = 1; bus.up_pc = pc; bus.up_taken = tk;
      bus.up_target = tgt; bus.up_ghr = g;
      tick();
      clear_in();
   endtask

   task automatic chk_pred(input string name, input bit v, input bit tk,
                           input logic [31:0] tg, input logic [7:0] g);
      chk({name, "_valid"},  32'(bus.pred_valid), 32'(v));
      chk({name, "_taken"},  32'(bus.pred_taken), 32'(tk));
      chk({name, "_target"}, bus.pred_target, tg);
      chk({name, "_ghr"},    32'(bus.pred_ghr), 32'(g));
   endtask

   // ---------------- vector table ----------------
   localparam int OP_LK_DIR = 0, OP_LK_COND = 1, OP_UP_DIR = 2;
   typedef struct {
      int          op;
      logic [31:0] pc;
      logic [31:0] tgt;
      bit          e_taken;
      logic [31:0] e_target;
   } vec_t;
   vec_t vecs [7];

   logic [31:0] pa, held_tgt;
   bit          lv, ls, fl, dir, cond, call, ret, uv, udir, ucond, ut;
   logic [31:0] pc, upc, utgt;
   logic [7:0]  ughr;
   int          k;

   initial begin
      vecs[0] = '{OP_LK_COND, 32'h1C000100, 32'h0,        1'b0, 32'h0};
      vecs[1] = '{OP_UP_DIR,  32'h1C000200, 32'h1C000400, 1'b0, 32'h0};
      vecs[2] = '{OP_LK_DIR,  32'h1C000200, 32'h0,        1'b1, 32'h1C000400};
      vecs[3] = '{OP_UP_DIR,  32'h1C000200, 32'h1C000500, 1'b0, 32'h0};
      vecs[4] = '{OP_LK_DIR,  32'h1C000200, 32'h0,        1'b1, 32'h1C000500};
      vecs[5] = '{OP_LK_DIR,  32'h1C000204, 32'h0,        1'b0, 32'h0};
      vecs[6] = '{OP_LK_COND, 32'h1C000200, 32'h0,        1'b0, 32'h0};

      do_reset();
      chk_pred("reset", 0, 0, 32'h0, 8'h0);

      for (int i = 0; i < 7; i++) begin
         case (vecs[i].op)
            OP_LK_DIR:  lookup(vecs[i].pc, 1, 0, 0, 0);
            OP_LK_COND: lookup(vecs[i].pc, 0, 1, 0, 0);
            default:    upd_dir(vecs[i].pc, vecs[i].tgt);
         endcase
         if (vecs[i].op == OP_UP_DIR)
            chk($sformatf("vec%0d_valid", i), 32'(bus.pred_valid), 32'h0);
         else
            chk_pred($sformatf("vec%0d", i), 1, vecs[i].e_taken, vecs[i].e_target, 8'h0);
      end

      // FIFO replacement: overwrite must not advance the pointer
      do_reset();
      upd_dir(32'h1C000200, 32'h1C000400);
      upd_dir(32'h1C000200, 32'h1C000500);
      for (int i = 0; i < BTB_NUM - 1; i++) upd_dir(32'h1C001000 + 32'(4 * i), 32'h1C008000 + 32'(4 * i));
      lookup(32'h1C000200, 1, 0, 0, 0);
      chk_pred("btb_keep_first", 1, 1, 32'h1C000500, 8'h0);
      upd_dir(32'h1C001000 + 32'(4 * (BTB_NUM - 1)), 32'h1C00F000);
      lookup(32'h1C000200, 1, 0, 0, 0);
      chk_pred("btb_evict_first", 1, 0, 32'h0, 8'h0);
      lookup(32'h1C001000 + 32'(4 * (BTB_NUM - 1)), 1, 0, 0, 0);
      chk_pred("btb_last_hit", 1, 1, 32'h1C00F000, 8'h0);
      lookup(32'h1C001000, 1, 0, 0, 0);
      chk_pred("btb_second_hit", 1, 1, 32'h1C008000, 8'h0);

      // gshare saturation at both ends; lookup PCs chosen so GHR^pc hits index 0xC0
      do_reset();
      for (int i = 0; i < 3; i++) upd_cond(32'h1C000300, 1, 32'h1C000340, 8'h0);
      lookup(32'h1C00031C, 0, 1, 0, 0);
      chk_pred("pht_strong_t", 1, 1, 32'h1C000340, 8'h07);
      upd_cond(32'h1C000300, 0, 32'h0, 8'h0);
      lookup(32'h1C000338, 0, 1, 0, 0);
      chk_pred("pht_sat_hi", 1, 1, 32'h1C000340, 8'h0E);
      for (int i = 0; i < 3; i++) upd_cond(32'h1C000300, 0, 32'h0, 8'h0);
      lookup(32'h1C0002C0, 0, 1, 0, 0);
      chk_pred("pht_sat_lo", 1, 0, 32'h0, 8'h70);

      // stall hold, flush, flush+update, same-cycle read-before-write, mid-run reset
      do_reset();
      upd_dir(32'h1C000600, 32'h1C000A00);
      lookup(32'h1C000600, 1, 0, 0, 0);
      chk_pred("stall_pre", 1, 1, 32'h1C000A00, 8'h0);
      bus.lk_valid = 1; bus.lk_pc = 32'h1C000700; bus.lk_is_cond = 1; bus.lk_stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_pred($sformatf("stall%0d", i), 1, 1, 32'h1C000A00, 8'h0);
      end
      bus.lk_stall = 0; bus.flush = 1;
      tick();
      chk("flush_valid", 32'(bus.pred_valid), 32'h0);
      bus.up_valid = 1; bus.up_is_direct = 1; bus.up_pc = 32'h1C000640; bus.up_target = 32'h1C000C00;
      tick();
      clear_in();
      chk("flush_upd_valid", 32'(bus.pred_valid), 32'h0);
      lookup(32'h1C000640, 1, 0, 0, 0);
      chk_pred("flush_upd_hit", 1, 1, 32'h1C000C00, 8'h0);
      bus.lk_valid = 1; bus.lk_pc = 32'h1C000680; bus.lk_is_direct = 1;
      bus.up_valid = 1; bus.up_is_direct = 1; bus.up_pc = 32'h1C000680; bus.up_target = 32'h1C000E00;
      tick();
      clear_in();
      chk_pred("rbw_old", 1, 0, 32'h0, 8'h0);
      lookup(32'h1C000680, 1, 0, 0, 0);
      chk_pred("rbw_new", 1, 1, 32'h1C000E00, 8'h0);
      bus.lk_valid = 1; bus.lk_pc = 32'h1C000600; bus.lk_is_direct = 1; rst = 1;
      tick();
      rst = 0;
      clear_in();
      chk("rst_mid_valid", 32'(bus.pred_valid), 32'h0);
      lookup(32'h1C000600, 1, 0, 0, 0);
      chk_pred("rst_mid_lost", 1, 0, 32'h0, 8'h0);

`ifdef BPU_RAS_EN
      do_reset();
      upd_dir(32'h1C000020, 32'h1C000800);
      lookup(32'h1C000010, 1, 0, 1, 0);
      lookup(32'h1C000020, 1, 0, 0, 1);
      chk_pred("ras_pop", 1, 1, 32'h1C000014, 8'h0);
      lookup(32'h1C000020, 1, 0, 0, 1);
      chk_pred("ras_empty", 1, 1, 32'h1C000800, 8'h0);
      for (int i = 0; i <= RAS_DEPTH; i++) lookup(32'h1C000100 + 32'(16 * i), 1, 0, 1, 0);
      for (int j = 0; j <= RAS_DEPTH; j++) begin
         lookup(32'h1C000020, 1, 0, 0, 1);
         if (j < RAS_DEPTH) pa = 32'h1C000104 + 32'(16 * (RAS_DEPTH - j));
         else pa = 32'h1C000800;
         chk_pred($sformatf("ras_lifo%0d", j), 1, 1, pa, 8'h0);
      end
`endif

      // randomized run against the model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         lv = ($urandom_range(0, 3) != 0);
         ls = ($urandom_range(0, 7) == 0);
         fl = ($urandom_range(0, 15) == 0);
         pc = 32'h1C000000 | ($urandom_range(0, 23) << 2);
         k = $urandom_range(0, 4);
         dir = (k == 1 || k == 3 || k == 4); cond = (k == 2); call = (k == 3); ret = (k == 4);
         uv = $urandom_range(0, 1) != 0;
         k = $urandom_range(0, 1);
         udir = (k == 0); ucond = (k == 1);
         ut = $urandom_range(0, 1) != 0;
         upc = 32'h1C000000 | ($urandom_range(0, 23) << 2);
         utgt = 32'h1C100000 | ($urandom_range(0, 255) << 2);
         ughr = ($urandom_range(0, 1) != 0) ? e_ghr : 8'($urandom_range(0, 255));
         bus.lk_valid = lv; bus.lk_stall = ls; bus.flush = fl; bus.lk_pc = pc;
         bus.lk_is_direct = dir; bus.lk_is_cond = cond; bus.lk_is_call = call; bus.lk_is_ret = ret;
         bus.up_valid = uv; bus.up_is_direct = udir; bus.up_is_cond = ucond; bus.up_taken = ut;
         bus.up_pc = upc; bus.up_target = utgt; bus.up_ghr = ughr;
         held_tgt = e_target;
         model_step(lv, ls, fl, pc, dir, cond, call, ret, uv, udir, ucond, ut, upc, utgt, ughr);
         tick();
         chk("rnd_valid", 32'(bus.pred_valid), 32'(e_valid));
         if (e_valid) begin
            chk("rnd_taken",  32'(bus.pred_taken), 32'(e_taken));
            chk("rnd_target", bus.pred_target, e_target);
            chk("rnd_ghr",    32'(bus.pred_ghr), 32'(e_ghr));
         end
      end
      clear_in();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the predecode-stage predictor.
- Contains a fully-associative BTB for direct jumps, and a gshare PHT plus target cache for conditional branches.
- Carries a history snapshot through the pipeline so commit-time training uses the history that made the prediction.
- Sits between fetch/predecode (lookup port) and writeback (update port). Returns a registered prediction one cycle after lookup.

Parameters:
- BTB_NUM, 16, BTB entries; power of 2, ≥2.
- BTB_TAG_WID, 12, BTB tag = pc[BTB_TAG_WID+1:2].
- BHR_WID, 8, global history width; PHT and target-cache depth = 2**BHR_WID.
- RAS_DEPTH, 8, return-stack entries; power of 2; used only with BPU_RAS_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- lk_valid  in  1  lookup request
- lk_stall  in  1  downstream stall; hold prediction outputs, accept no new lookup
- lk_pc  in  32  PC of predecoded instruction
- lk_is_direct  in  1  b/bl/jirl
- lk_is_cond  in  1  beq/bne/blt/bge/bltu/bgeu
- lk_is_call  in  1  bl (RAS push)
- lk_is_ret  in  1  jirl r0,r1,0 (RAS pop)
- flush  in  1  predict error / exception / ertn
- pred_valid  out  1  prediction result valid
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted target; 0 when not taken
- pred_ghr  out  BHR_WID  history snapshot used for this prediction
- up_valid  in  1  commit-time training
- up_pc  in  32  committed PC
- up_is_direct  in  1  committed direct jump
- up_is_cond  in  1  committed conditional branch
- up_taken  in  1  actual outcome
- up_target  in  32  actual target
- up_ghr  in  BHR_WID  pred_ghr carried with the instruction

Behaviour:
- Reset:
  - pred_valid=0, pred_taken=0, pred_target=0, pred_ghr=0.
  - GHR=0; BTB valid bits=0; BTB FIFO pointer=0.
  - PHT counters=2'b01 (weakly not-taken); TC valid bits=0; RAS count/pointer=0.
  - rst takes priority over every other input; asserting it mid-operation discards all state.
- Lookup acceptance: a lookup is accepted when lk_valid & !lk_stall & !flush.
- Prediction outputs:
  - Outputs register on acceptance, so latency is 1 cycle.
  - While lk_stall=1, all pred_* outputs hold.
  - When !lk_stall and no lookup is accepted, pred_valid<=0.
  - flush forces pred_valid<=0 next cycle; tables are not altered.
- BTB lookup: hit = any entry with valid & tag==lk_pc[BTB_TAG_WID+1:2]. At most one entry can hit, by the update rule below.
- PHT lookup: idx = GHR ^ lk_pc[BHR_WID+1:2]; pred_ghr<=GHR.
- Prediction decision:
  - Direct: taken = BTB hit; target = BTB target.
  - Cond: taken = PHT[idx][1] & (BTB hit | TC_valid[idx]); target = BTB target if hit, else TC[idx].
  - Any other instruction, or a miss: taken=0, target=0.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Saturating: increment on taken, decrement on not-taken, no wrap at 00/11.
- Update, direct (up_valid & up_is_direct):
  - On tag hit, overwrite that entry's target in place; the pointer does not move.
  - On miss, write the entry at the FIFO pointer and set its valid bit; pointer increments modulo BTB_NUM (wraps, evicting the oldest entry).
- Update, conditional (up_valid & up_is_cond):
  - uidx = up_ghr ^ up_pc[BHR_WID+1:2].
  - PHT[uidx] saturates toward up_taken.
  - If up_taken: TC[uidx]<=up_target and TC_valid[uidx]<=1.
  - GHR <= {GHR[BHR_WID-2:0], up_taken}. GHR is committed, never speculative.
- Same-cycle lookup and update on the same entry/index: the lookup sees the pre-update value (read-before-write).
- Simultaneous flush and update: the update still applies.

Optional Feature:
- Macro: BPU_RAS_EN.
- Defined:
  - RAS of RAS_DEPTH×32 is instantiated.
  - An accepted lookup with lk_is_call pushes lk_pc+4.
  - An accepted lookup with lk_is_ret pops; if count>0, predict taken with the popped target, overriding the BTB.
  - Push when full: overwrites the oldest entry (pointer wraps, count stays at RAS_DEPTH).
  - Pop when empty: falls back to the BTB result; count stays 0.
  - flush leaves the RAS unchanged; rst empties it.
- Undefined: no RAS logic; lk_is_call/lk_is_ret are ignored and returns are predicted through the BTB as direct jumps.

Test Plan:
- After rst, lookup pc=0x1C000100 with lk_is_cond=1 -> next cycle pred_valid=1, pred_taken=0, pred_target=0.
- Update direct pc=0x1C000200 target=0x1C000400; then lookup lk_is_direct at that pc -> pred_taken=1, pred_target=0x1C000400. Update the same pc with target 0x1C000500 -> same BTB slot overwritten, FIFO pointer unchanged.
- BTB_NUM+1 distinct direct updates -> first entry evicted; lookup of the first pc predicts not-taken, lookup of the last pc hits.
- Two taken updates of cond pc=0x1C000300, target=0x1C000340, each up_ghr = current pred_ghr -> counter 01→10→11; lookup with matching GHR predicts taken, target 0x1C000340. Three not-taken updates -> saturates at 00, predicts not-taken.
- lk_stall held 3 cycles after a lookup -> pred_* stable. flush with lk_valid=1 -> pred_valid=0 next cycle.
- BPU_RAS_EN: call at 0x1C000010, then ret -> pred_taken=1, target=0x1C000014. Ret with empty RAS -> falls back to BTB. RAS_DEPTH+1 calls then RAS_DEPTH+1 rets -> newest RAS_DEPTH targets popped in LIFO order, then BTB fallback.
